// File: rtl/wisc_cache_pkg.sv
// Shared definitions for the cache miss-handling logic: fill FSM state
// encoding, block geometry and default bus widths.
package wisc_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int DEFAULT_AWIDTH  = 16;
    localparam int DEFAULT_DWIDTH  = 16;
    localparam int DEFAULT_CNT_W   = 4;
    localparam int WORDS_PER_BLOCK = 8;

    // Clears the byte offset within a 16-byte block.
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;

    // Fixed read latency of the shared main memory, in cycles.
    localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop bank with synchronous active-high reset.
module dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fill_counter.sv
// Up-counter used to track issued and received words of a block fill.
module fill_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear takes priority so a new fill always starts from word 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches the 8-word block around a missed
// address and streams each returning word into the data array.
module cache_fill_fsm
    import wisc_cache_pkg::*;
#(
    parameter int AWIDTH          = DEFAULT_AWIDTH,
    parameter int DWIDTH          = DEFAULT_DWIDTH,
    parameter int WORDS_PER_BLOCK = wisc_cache_pkg::WORDS_PER_BLOCK,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [AWIDTH-1:0] miss_address,
    input  logic [DWIDTH-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [AWIDTH-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        data_word_offset,
    output logic [DWIDTH-1:0] data_out,
    output logic              write_tag_array
);

    localparam int               OFF_W       = $clog2(WORDS_PER_BLOCK);
    localparam logic [AWIDTH-1:0] OFFSET_MASK = AWIDTH'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(WORDS_PER_BLOCK - 1);

    fill_state_t       state;
    fill_state_t       state_next;
    logic              state_q;
    logic              state_d;
    logic [AWIDTH-1:0] base_addr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              in_fill;
    logic              start_fill;
    logic              issuing;
    logic              receiving;
    logic              last_word;
    logic              cnt_clear;

    assign state = fill_state_t'(state_q);

    // Reset masks everything combinationally so a mid-fill reset cycle
    // cannot leak a data or tag write.
    assign in_fill    = (state == FILL) && !rst;
    assign start_fill = (state == IDLE) && miss_detected && !rst;
    assign issuing    = in_fill && (issue_cnt < FULL_CNT);
    assign receiving  = in_fill && memory_data_valid;
    assign last_word  = receiving && (recv_cnt == LAST_IDX);
    assign cnt_clear  = start_fill || last_word;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_detected) state_next = FILL;
            FILL:    if (last_word)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign state_d = state_next;

    dff #(.WIDTH(1)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_q)
    );

    dff #(.WIDTH(AWIDTH)) u_base_reg (
        .clk (clk),
        .rst (rst),
        .en  (start_fill),
        .d   (miss_address & ~OFFSET_MASK),
        .q   (base_addr)
    );

    fill_counter #(.CNT_W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (issuing),
        .count (issue_cnt)
    );

    fill_counter #(.CNT_W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (receiving),
        .count (recv_cnt)
    );

    // The word offset is OR-ed into the aligned base, so the address can
    // never carry out of the block even at the top of memory.
    assign memory_address   = issuing
                              ? (base_addr | AWIDTH'({issue_cnt[OFF_W-1:0], 1'b0}))
                              : '0;
    assign fsm_busy         = in_fill;
    assign mem_read_en      = issuing;
    assign write_data_array = receiving;
    assign data_word_offset = in_fill ? recv_cnt[2:0] : 3'd0;
    assign data_out         = in_fill ? memory_data : '0;
    assign write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a driver queues expected reads and
// writes per fill, and a negedge monitor pops and compares them.
module tb_cache_fill_fsm;
    import wisc_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_word_offset;
    logic [15:0] data_out;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_offset  (data_word_offset),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic [2:0]  off;
        logic [15:0] data;
        logic        tag;
    } wr_exp_t;

    rd_exp_t exp_rd[$];
    wr_exp_t exp_wr[$];
    rd_exp_t mon_rd;
    wr_exp_t mon_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int busy_cnt   = 0;
    int busy_first = -1;
    int busy_last  = -1;

    logic                   rd_seen = 1'b0;
    logic [MEM_LATENCY-1:0] pipe    = '0;
    bit                     pattern_mode = 1'b0;
    bit                     pat[$];
    int                     mem_k = 0;
    logic [15:0]            mem_base = 16'h0000;

    int lat_vc[8] = '{5, 6, 7, 8, 9, 10, 11, 12};
    int irr_vc[8] = '{9, 12, 13, 15, 16, 17, 18, 19};
    bit irr_pat[11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=%0h required=no event at cycle %0d", name, act, cyc);
    endtask

    // Monitor: every read and data write the DUT presents must match the
    // oldest queued expectation, including the cycle it appears in.
    always @(negedge clk) begin
        rd_seen = mem_read_en;
        if (fsm_busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (mem_read_en) begin
            if (exp_rd.size() == 0) begin
                flag_unexpected("unexpected_read", 32'(memory_address));
            end else begin
                mon_rd = exp_rd.pop_front();
                check_output("read_cycle", cyc, mon_rd.cyc);
                check_output("read_addr", 32'(memory_address), 32'(mon_rd.addr));
            end
        end
        if (write_data_array) begin
            if (exp_wr.size() == 0) begin
                flag_unexpected("unexpected_write", 32'(data_out));
            end else begin
                mon_wr = exp_wr.pop_front();
                check_output("write_cycle", cyc, mon_wr.cyc);
                check_output("write_offset", 32'(data_word_offset), 32'(mon_wr.off));
                check_output("write_data", 32'(data_out), 32'(mon_wr.data));
                check_output("write_tag", 32'(write_tag_array), 32'(mon_wr.tag));
            end
        end else if (write_tag_array) begin
            flag_unexpected("tag_without_data", 32'(write_tag_array));
        end
    end

    // Advances one clock and plays the memory model for the new cycle.
    task automatic tick();
        logic v;
        @(posedge clk);
        #1;
        pipe = {pipe[MEM_LATENCY-2:0], rd_seen};
        if (pattern_mode) v = (pat.size() > 0) ? pat.pop_front() : 1'b0;
        else              v = pipe[MEM_LATENCY-1];
        memory_data_valid = v;
        memory_data       = v ? (mem_base + 16'(mem_k)) : 16'hDEAD;
        if (v) mem_k++;
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] dbase);
        miss_detected = 1'b1;
        miss_address  = addr;
        mem_k         = 0;
        mem_base      = dbase;
        t0            = cyc;
        busy_cnt      = 0;
        busy_first    = -1;
        busy_last     = -1;
    endtask

    task automatic expect_fill(input logic [15:0] base, input logic [15:0] dbase, input int vc[8]);
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back('{cyc: t0 + 1 + i, addr: base + 16'(2 * i)});
            exp_wr.push_back('{cyc: t0 + vc[i], off: 3'(i), data: dbase + 16'(i), tag: (i == 7)});
        end
    endtask

    task automatic check_busy(input int n);
        check_output("busy_count", busy_cnt, n);
        check_output("busy_first", busy_first - t0, 1);
        check_output("busy_last", busy_last - t0, n);
    endtask

    task automatic check_drained();
        check_output("reads_left", exp_rd.size(), 0);
        check_output("writes_left", exp_wr.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "_ctrl"},
                     32'({fsm_busy, mem_read_en, write_data_array, write_tag_array, data_word_offset}), 32'd0);
        check_output({name, "_bus"}, {memory_address, data_out}, 32'd0);
    endtask

    task automatic run_latency_fill(input logic [15:0] addr, input logic [15:0] base, input logic [15:0] dbase);
        apply_stimulus(addr, dbase);
        expect_fill(base, dbase, lat_vc);
        tick();
        miss_detected = 1'b0;
        repeat (11) tick();
        @(negedge clk);
        #1;
        check_busy(12);
        check_drained();
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'hDEAD;

        // Reset: a miss presented during reset must be ignored.
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        tick();
        @(negedge clk);
        #1;
        check_all_zero("during_reset");
        tick();
        rst           = 1'b0;
        miss_detected = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check_all_zero("after_reset");
        repeat (2) tick();

        $display("[TB] basic fill 1234");
        run_latency_fill(16'h1234, 16'h1230, 16'hA000);

        $display("[TB] back-to-back miss 00F0");
        tick();
        check_output("idle_after_fill", 32'(fsm_busy), 32'd0);
        run_latency_fill(16'h00F0, 16'h00F0, 16'hC000);
        repeat (6) tick();

        $display("[TB] inputs ignored during fill");
        apply_stimulus(16'h1234, 16'h3000);
        expect_fill(16'h1230, 16'h3000, lat_vc);
        tick();
        miss_address = 16'h5678;
        repeat (10) tick();
        tick();
        miss_detected = 1'b0;
        @(negedge clk);
        #1;
        check_busy(12);
        check_drained();
        repeat (4) tick();
        @(negedge clk);
        #1;
        check_output("no_restart", busy_cnt, 12);

        $display("[TB] reset mid-fill");
        repeat (2) tick();
        apply_stimulus(16'h1234, 16'hA000);
        for (int i = 0; i < 5; i++) begin
            exp_rd.push_back('{cyc: t0 + 1 + i, addr: 16'h1230 + 16'(2 * i)});
        end
        exp_wr.push_back('{cyc: t0 + 5, off: 3'd0, data: 16'hA000, tag: 1'b0});
        tick();
        miss_detected = 1'b0;
        repeat (4) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("after_mid_reset");
        check_output("busy_before_reset", busy_cnt, 5);
        check_drained();
        repeat (6) tick();
        run_latency_fill(16'h2468, 16'h2460, 16'hE000);
        repeat (6) tick();

        $display("[TB] top-of-memory block");
        run_latency_fill(16'hFFFF, 16'hFFF0, 16'hD000);
        repeat (6) tick();

        $display("[TB] irregular valid timing");
        pattern_mode = 1'b1;
        for (int i = 0; i < 8; i++) pat.push_back(1'b0);
        foreach (irr_pat[i]) pat.push_back(irr_pat[i]);
        apply_stimulus(16'h4C8A, 16'hB000);
        expect_fill(16'h4C80, 16'hB000, irr_vc);
        tick();
        miss_detected = 1'b0;
        repeat (18) tick();
        @(negedge clk);
        #1;
        check_busy(19);
        check_drained();
        tick();
        pattern_mode = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check_all_zero("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
